ysyx_041514_clint: RTL
======================

# ysyx_041514_clint

Parametrised core-local interruptor, the successor to the single-hart mtime block. It holds one shared 64-bit `mtime` advanced by a programmable prescaler, plus per-hart `mtimecmp` and `msip` registers for `NHART` harts. It adds byte-strobed writes, a registered one-cycle read response with error reporting, and registered `mtip`/`msip` interrupt outputs. It sits on the NPC data-bus MMIO path beside the CSR unit, which consumes the interrupt lines.

## Interface
- `NHART`, 1: number of harts; legal range 1..16.
- `XLEN`, 64: data-bus width; `mtime` and `mtimecmp` are always 64 bits.
- `ADDR_W`, 32: address width.
- `BASE_ADDR`, 32'h0200_0000: region base; offsets below are relative to it.
- `TICK_DIV`, 1: `mtime` increments once every `TICK_DIV` clock cycles; legal range 1..65535.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `clint_valid_i`  in  1  request strobe; every request is accepted in the cycle it is presented.
- `clint_write_i`  in  1  1 = write, 0 = read.
- `clint_addr_i`  in  ADDR_W  byte address.
- `clint_wdata_i`  in  XLEN  write data.
- `clint_wstrb_i`  in  XLEN/8  byte-lane write enables.
- `clint_rvalid_o`  out  1  response pulse, one cycle after every request.
- `clint_rdata_o`  out  XLEN  read data, valid while `clint_rvalid_o` is 1.
- `clint_err_o`  out  1  the request was unmapped; valid while `clint_rvalid_o` is 1.
- `mtip_o`  out  NHART  machine timer interrupt, one bit per hart.
- `msip_o`  out  NHART  machine software interrupt, one bit per hart.

## Operation
- Address map:
  - `msip[i]` at offset 0x0000+4i. Only bit 0 is implemented; other bits read 0.
  - `mtimecmp[i]` at offset 0x4000+8i. 8-byte aligned.
  - `mtime` at offset 0xBFF8.
- Error responses:
  - Any other offset, or an `msip` index ≥ NHART, returns `err=1` and `rdata=0`, with no state change.
  - A 64-bit register address not 8-byte aligned also returns `err=1`.
- Lane selection:
  - 64-bit registers use `wdata[63:0]`, each byte gated by `wstrb`.
  - `msip` uses lane `addr[2]`: bit 0 comes from `wdata[32*addr[2]]` and is written only if `wstrb[4*addr[2]]` is 1.
- Prescaler:
  - Counter `pre` counts 0..TICK_DIV-1 and wraps to 0.
  - `tick = (pre == TICK_DIV-1)`; with TICK_DIV=1, `tick` is always 1.
- `mtime` update, in priority order:
  - A write to `mtime` merges the strobed bytes and resets `pre` to 0; no increment occurs that cycle.
  - Otherwise, if `tick`, `mtime` increments by 1, wrapping modulo 2^64.
- `mtimecmp[i]` is written with strobe merge only. Reset value is all-ones, so no timer interrupt can fire before software programs it.
- Interrupt outputs:
  - `mtip_o[i]` register loads `(mtime_q >= mtimecmp_q[i])`, unsigned, every cycle.
  - `msip_o[i]` equals the `msip[i]` register bit.
- Reads return the register value as it stands in the request cycle, before that cycle's update. A read of `msip` places the bit on lane `addr[2]`, bit 0 of that lane.
- Writes also produce a response: `rvalid=1`, `rdata=0`.

## Timing
- Reset values: `mtime`=0, `pre`=0, `mtimecmp[*]`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, `mtip_o`=0, `clint_rvalid_o`=0, `clint_rdata_o`=0, `clint_err_o`=0.
- Response timing: a request in cycle N produces `rvalid`/`rdata`/`err` in cycle N+1 only. Back-to-back requests give back-to-back responses.
- A write in cycle N takes effect on the register at the edge ending cycle N.
- `mtip_o` reflects that new value one cycle later, at N+2.
- Reset asserted mid-operation: all state returns to reset values at the next edge, and any pending response is dropped (`rvalid`=0).
- Simultaneous `tick` and `mtime` write: the write wins and the tick is lost.
- `mtime` wrapping from all-ones to 0 deasserts `mtip` unless `mtimecmp`=0.

## Test plan
- **Reset defaults:** assert reset, release, then read offset 0xBFF8 → rdata=0, err=0. `mtip_o` stays 0 for 100 cycles with default `mtimecmp`.
- **Prescaler:** TICK_DIV=4, run 40 cycles after reset, read `mtime` → 10. Write `mtime`=5 mid-count → next increment occurs exactly 4 cycles after the write.
- **Timer compare:** NHART=2, write `mtimecmp[1]`=20 at TICK_DIV=1 → `mtip_o`=2'b10 exactly two cycles after `mtime` reaches 20. Write `mtimecmp[1]`=all-ones → `mtip_o[1]` clears two cycles later.
- **Byte strobes:** write `mtimecmp[0]` with wdata=64'h1122334455667788, wstrb=8'h0F → readback 64'hFFFFFFFF55667788.
- **msip lanes:** write offset 0x0004, wdata bit 32=1, wstrb=8'hF0 → `msip_o[1]`=1 and readback at 0x0004 has rdata[32]=1. The same write with wstrb=8'h0F leaves `msip_o[1]` unchanged.
- **Errors:** read offset 0x0008 with NHART=2 → err=1, rdata=0. Read 0x4004 → err=1. Back-to-back read/write/read → three consecutive `rvalid` pulses.

Source files
------------

// File: rtl/ysyx_041514_clint_if.sv
// Request/response bus between the NPC data path and the CLINT.
// Signal suffixes are from the CLINT's point of view.
interface ysyx_041514_clint_if #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 64
);
   logic                clint_valid_i;
   logic                clint_write_i;
   logic [ADDR_W-1:0]   clint_addr_i;
   logic [XLEN-1:0]     clint_wdata_i;
   logic [XLEN/8-1:0]   clint_wstrb_i;
   logic                clint_rvalid_o;
   logic [XLEN-1:0]     clint_rdata_o;
   logic                clint_err_o;

   modport master (
      output clint_valid_i, clint_write_i, clint_addr_i, clint_wdata_i, clint_wstrb_i,
      input  clint_rvalid_o, clint_rdata_o, clint_err_o
   );

   modport slave (
      input  clint_valid_i, clint_write_i, clint_addr_i, clint_wdata_i, clint_wstrb_i,
      output clint_rvalid_o, clint_rdata_o, clint_err_o
   );
endinterface

// File: rtl/ysyx_041514_clint.sv
// Core-local interruptor: shared prescaled 64-bit mtime, per-hart mtimecmp/msip,
// byte-strobed writes and a registered one-cycle response with error flag.
module ysyx_041514_clint #(
   parameter int                NHART     = 1,
   parameter int                XLEN      = 64,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0200_0000,
   parameter int                TICK_DIV  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   ysyx_041514_clint_if.slave   clint_bus,
   output logic [NHART-1:0]     mtip_o,
   output logic [NHART-1:0]     msip_o
);
   localparam int               PRE_W    = 16;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [63:0]       mtime_q, mtime_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [63:0]       mtimecmp_q [NHART];
   logic [63:0]       mtimecmp_d [NHART];
   logic [NHART-1:0]  msip_q, msip_d;
   logic [NHART-1:0]  mtip_q;
   logic              rvalid_q;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [ADDR_W-1:0] offset;
   logic              in_region;
   logic              lane;
   logic              hit_mtime;
   logic              wr;
   logic [63:0]       wdata64;
   logic [7:0]        wstrb8;
   logic [NHART-1:0]  cmp_sel;
   logic [NHART-1:0]  msip_sel;

   assign offset    = clint_bus.clint_addr_i - BASE_ADDR;
   assign in_region = (offset[ADDR_W-1:16] == '0);
   assign lane      = offset[2];
   assign hit_mtime = in_region && (offset[15:0] == 16'hBFF8);
   assign wr        = clint_bus.clint_valid_i && clint_bus.clint_write_i;
   assign wdata64   = clint_bus.clint_wdata_i[63:0];
   assign wstrb8    = clint_bus.clint_wstrb_i[7:0];

   // Exact-address decode: anything not matching a per-hart slot is an error.
   generate
      for (genvar gi = 0; gi < NHART; gi++) begin : g_sel
         assign msip_sel[gi] = in_region && (offset[15:14] == 2'b00) &&
                               (offset[1:0] == 2'b00) && (offset[13:2] == 12'(gi));
         assign cmp_sel[gi]  = in_region && (offset[15:14] == 2'b01) &&
                               (offset[2:0] == 3'b000) && (offset[13:3] == 11'(gi));
      end
   endgenerate

   function automatic logic [63:0] strobe_merge(input logic [63:0] old_v,
                                                input logic [63:0] new_v,
                                                input logic [7:0]  strb);
      logic [63:0] res;
      for (int b = 0; b < 8; b++) begin
         res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      end
      return res;
   endfunction

   // A software write to mtime restarts the prescaler and swallows that cycle's tick.
   always_comb begin
      mtime_d = mtime_q;
      pre_d   = pre_q + PRE_W'(1);
      if (wr && hit_mtime) begin
         mtime_d = strobe_merge(mtime_q, wdata64, wstrb8);
         pre_d   = '0;
      end else if (pre_q == PRE_LAST) begin
         mtime_d = mtime_q + 64'd1;
         pre_d   = '0;
      end
   end

   always_comb begin
      msip_d = msip_q;
      for (int h = 0; h < NHART; h++) begin
         mtimecmp_d[h] = mtimecmp_q[h];
         if (wr && cmp_sel[h]) begin
            mtimecmp_d[h] = strobe_merge(mtimecmp_q[h], wdata64, wstrb8);
         end
         if (wr && msip_sel[h] && wstrb8[{lane, 2'b00}]) begin
            msip_d[h] = wdata64[{lane, 5'b00000}];
         end
      end
   end

   always_comb begin
      logic [63:0] cmp_rd;
      logic        msip_rd;
      cmp_rd  = '0;
      msip_rd = 1'b0;
      rdata_d = '0;
      err_d   = 1'b0;
      for (int h = 0; h < NHART; h++) begin
         if (cmp_sel[h]) begin
            cmp_rd = mtimecmp_q[h];
         end
         msip_rd = msip_rd | (msip_sel[h] & msip_q[h]);
      end
      if (!(hit_mtime || (|cmp_sel) || (|msip_sel))) begin
         err_d = 1'b1;
      end else if (!clint_bus.clint_write_i) begin
         if (hit_mtime) begin
            rdata_d[63:0] = mtime_q;
         end else if (|cmp_sel) begin
            rdata_d[63:0] = cmp_rd;
         end else begin
            rdata_d[63:0] = lane ? {31'd0, msip_rd, 32'd0} : {63'd0, msip_rd};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q  <= '0;
         pre_q    <= '0;
         msip_q   <= '0;
         mtip_q   <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         for (int h = 0; h < NHART; h++) begin
            mtimecmp_q[h] <= '1;
         end
      end else begin
         mtime_q  <= mtime_d;
         pre_q    <= pre_d;
         msip_q   <= msip_d;
         for (int h = 0; h < NHART; h++) begin
            mtimecmp_q[h] <= mtimecmp_d[h];
            mtip_q[h]     <= (mtime_q >= mtimecmp_q[h]);
         end
         rvalid_q <= clint_bus.clint_valid_i;
         rdata_q  <= clint_bus.clint_valid_i ? rdata_d : '0;
         err_q    <= clint_bus.clint_valid_i & err_d;
      end
   end

   assign clint_bus.clint_rvalid_o = rvalid_q;
   assign clint_bus.clint_rdata_o  = rdata_q;
   assign clint_bus.clint_err_o    = err_q;
   assign mtip_o                   = mtip_q;
   assign msip_o                   = msip_q;
endmodule
